mem_arb: RTL and testbench

Three-way arbiter sharing one memory port (the ram reqValid/busy/respValid protocol) between the top-level loader, the load/store unit and the instruction fetch unit. Each requester has its own single-entry request buffer. A two-state FSM issues one transaction at a time to memory and routes the response back to the requester that owns it. Lets the core run on a single-ported ram instead of separate ram/mread instances.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_if.sv | 61 ++++++
 rtl/mem_arb_slot.sv | 27 ++
 rtl/mem_arb.sv | 160 ++++++++++++++++
 tb/tb_mem_arb.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the three-way single-port memory arbiter.
// Request bundle layout is common to all three requester slots.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_TOP,
        OWN_LSU,
        OWN_IFU
    } arb_owner_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [3:0]            wbmask;
        logic                  wen;
    } arb_req_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester ports, memory port and error flag of mem_arb.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              top_reqValid;
    logic              lsu_reqValid;
    logic              ifu_reqValid;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] lsu_addr;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] top_wdata;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_wen;
    logic [3:0]        lsu_wbmask;
    logic              top_busy;
    logic              lsu_busy;
    logic              ifu_busy;
    logic              top_respValid;
    logic              lsu_respValid;
    logic              ifu_respValid;
    logic [DATA_W-1:0] lsu_rdata;
    logic [DATA_W-1:0] ifu_rdata;
    logic              mem_reqValid;
    logic              mem_wen;
    logic [3:0]        mem_wbmask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_busy;
    logic              mem_respValid;
    logic [DATA_W-1:0] mem_rdata;
    logic              arb_err;

    modport slave (
        input  top_reqValid, lsu_reqValid, ifu_reqValid,
        input  top_addr, lsu_addr, ifu_addr,
        input  top_wdata, lsu_wdata, lsu_wen, lsu_wbmask,
        output top_busy, lsu_busy, ifu_busy,
        output top_respValid, lsu_respValid, ifu_respValid,
        output lsu_rdata, ifu_rdata,
        output mem_reqValid, mem_wen, mem_wbmask,
        output mem_addr, mem_wdata,
        input  mem_busy, mem_respValid, mem_rdata,
        output arb_err
    );

    modport master (
        output top_reqValid, lsu_reqValid, ifu_reqValid,
        output top_addr, lsu_addr, ifu_addr,
        output top_wdata, lsu_wdata, lsu_wen, lsu_wbmask,
        input  top_busy, lsu_busy, ifu_busy,
        input  top_respValid, lsu_respValid, ifu_respValid,
        input  lsu_rdata, ifu_rdata,
        input  mem_reqValid, mem_wen, mem_wbmask,
        input  mem_addr, mem_wdata,
        output mem_busy, mem_respValid, mem_rdata,
        input  arb_err
    );

endinterface

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: single-entry request buffer for one requester.
// A request is taken only while the slot is empty; clear frees it.
module mem_arb_slot
    import mem_arb_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     req_valid,
    input  arb_req_t req_in,
    input  logic     clear,
    output logic     valid,
    output arb_req_t entry
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (req_valid && !valid) begin
            valid <= 1'b1;
            entry <= req_in;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between the loader, LSU and IFU.
// One transaction in flight; the response is steered back to its owner.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int MAX_LSU_STREAK = 4,
    parameter int TIMEOUT        = 255
) (
    input logic      clock,
    input logic      reset,
    mem_arb_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(MAX_LSU_STREAK + 1);

    arb_state_t       state;
    arb_owner_t       owner;
    arb_owner_t       win;
    logic [CNT_W-1:0] wait_cnt;
    logic [STK_W-1:0] streak;
    logic             err_q;

    arb_req_t top_in, lsu_in, ifu_in;
    arb_req_t top_q, lsu_q, ifu_q, win_req;
    logic     top_v, lsu_v, ifu_v;
    logic     lsu_blocked, g_top, g_lsu, g_ifu;
    logic     issue, timed_out, done;
    logic     top_done, lsu_done, ifu_done;
    logic [DATA_W-1:0] resp_data;

    assign top_in = '{addr:   ARB_ADDR_W'(bus.top_addr),
                      wdata:  ARB_DATA_W'(bus.top_wdata),
                      wbmask: 4'b1111,
                      wen:    1'b1};
    assign lsu_in = '{addr:   ARB_ADDR_W'(bus.lsu_addr),
                      wdata:  ARB_DATA_W'(bus.lsu_wdata),
                      wbmask: bus.lsu_wbmask,
                      wen:    bus.lsu_wen};
    assign ifu_in = '{addr:   ARB_ADDR_W'(bus.ifu_addr),
                      wdata:  '0,
                      wbmask: 4'b0000,
                      wen:    1'b0};

    mem_arb_slot u_top (
        .clock,
        .reset,
        .req_valid (bus.top_reqValid),
        .req_in    (top_in),
        .clear     (top_done),
        .valid     (top_v),
        .entry     (top_q)
    );

    mem_arb_slot u_lsu (
        .clock,
        .reset,
        .req_valid (bus.lsu_reqValid),
        .req_in    (lsu_in),
        .clear     (lsu_done),
        .valid     (lsu_v),
        .entry     (lsu_q)
    );

    mem_arb_slot u_ifu (
        .clock,
        .reset,
        .req_valid (bus.ifu_reqValid),
        .req_in    (ifu_in),
        .clear     (ifu_done),
        .valid     (ifu_v),
        .entry     (ifu_q)
    );

    // LSU yields to a waiting IFU once it has used up its streak
    assign lsu_blocked = ifu_v && (streak == STK_W'(MAX_LSU_STREAK));
    assign g_top = top_v;
    assign g_lsu = !top_v && lsu_v && !lsu_blocked;
    assign g_ifu = !top_v && !g_lsu && ifu_v;

    assign issue = !reset && (state == ARB_IDLE) && !bus.mem_busy
                   && (top_v || lsu_v || ifu_v);

    always_comb begin
        win     = OWN_TOP;
        win_req = '0;
        unique case (1'b1)
            g_top: begin
                win     = OWN_TOP;
                win_req = top_q;
            end
            g_lsu: begin
                win     = OWN_LSU;
                win_req = lsu_q;
            end
            g_ifu: begin
                win     = OWN_IFU;
                win_req = ifu_q;
            end
            default: ;
        endcase
    end

    // a real response in the last wait cycle beats the timeout
    assign timed_out = (state == ARB_WAIT) && !bus.mem_respValid
                       && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign done = !reset && (state == ARB_WAIT)
                  && (bus.mem_respValid || timed_out);
    assign resp_data = timed_out ? '1 : bus.mem_rdata;

    assign top_done = done && (owner == OWN_TOP);
    assign lsu_done = done && (owner == OWN_LSU);
    assign ifu_done = done && (owner == OWN_IFU);

    assign bus.top_busy      = top_v;
    assign bus.lsu_busy      = lsu_v;
    assign bus.ifu_busy      = ifu_v;
    assign bus.top_respValid = top_done;
    assign bus.lsu_respValid = lsu_done;
    assign bus.ifu_respValid = ifu_done;
    assign bus.lsu_rdata     = lsu_done ? resp_data : '0;
    assign bus.ifu_rdata     = ifu_done ? resp_data : '0;

    assign bus.mem_reqValid = issue;
    assign bus.mem_wen      = issue && win_req.wen;
    assign bus.mem_wbmask   = issue ? win_req.wbmask : 4'b0000;
    assign bus.mem_addr     = issue ? ADDR_W'(win_req.addr) : '0;
    assign bus.mem_wdata    = issue ? DATA_W'(win_req.wdata) : '0;
    assign bus.arb_err      = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= OWN_TOP;
            wait_cnt <= '0;
            streak   <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (issue) begin
                        state    <= ARB_WAIT;
                        owner    <= win;
                        wait_cnt <= '0;
                    end
                end
                ARB_WAIT: begin
                    if (done) state <= ARB_IDLE;
                    else      wait_cnt <= wait_cnt + 1'b1;
                end
            endcase
            if (timed_out) err_q <= 1'b1;
            if (!ifu_v || (issue && g_ifu)) streak <= '0;
            else if (issue && g_lsu)        streak <= streak + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and randomized checks of mem_arb against a
// transaction-level model of the arbiter's rules.
module tb_mem_arb;

    localparam int TMO  = 8;
    localparam int MAXS = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arb #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_LSU_STREAK(MAXS),
        .TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: pending request per port, one in-flight owner
    bit          pv[3];
    bit          pw[3];
    logic [3:0]  pm[3];
    logic [31:0] pa[3];
    logic [31:0] pd[3];
    bit          fly;
    bit          err;
    int          own, iss, lat, streak, cyc;
    bit          mem_auto;

    logic [2:0]  o_busy, o_resp;
    logic        o_mreq, o_mwen, o_err;
    logic [3:0]  o_mmask;
    logic [31:0] o_maddr, o_mwdata, o_lrd, o_ird;

    task automatic idle_inputs();
        reset             = 1'b0;
        bus.top_reqValid  = 1'b0;
        bus.lsu_reqValid  = 1'b0;
        bus.ifu_reqValid  = 1'b0;
        bus.top_addr      = '0;
        bus.lsu_addr      = '0;
        bus.ifu_addr      = '0;
        bus.top_wdata     = '0;
        bus.lsu_wdata     = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wbmask    = 4'b0000;
        bus.mem_busy      = 1'b0;
        bus.mem_respValid = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic tick();
        int          w;
        bit          e_iss, e_done, e_to;
        bit          req[3];
        logic [2:0]  e_resp;
        logic [69:0] e_mem;
        logic [31:0] e_rd, e_lrd, e_ird;
        if (mem_auto) begin
            if (fly) bus.mem_respValid = (lat != 0) && (cyc == iss + lat);
            else     bus.mem_respValid = ($urandom_range(0, 9) == 0);
            bus.mem_rdata = $urandom;
        end
        w = 0;
        e_iss = 0;
        e_done = 0;
        e_to = 0;
        if (!reset && !fly && (pv[0] || pv[1] || pv[2]) && !bus.mem_busy) begin
            e_iss = 1;
            if (pv[0])                                 w = 0;
            else if (pv[1] && !(pv[2] && streak >= MAXS)) w = 1;
            else                                       w = 2;
        end
        if (!reset && fly) begin
            if (bus.mem_respValid) e_done = 1;
            else if (cyc - iss == TMO) begin
                e_done = 1;
                e_to = 1;
            end
        end
        e_resp = '0;
        if (e_done) e_resp[2-own] = 1'b1;
        e_rd  = e_to ? 32'hFFFF_FFFF : bus.mem_rdata;
        e_lrd = (e_done && own == 1) ? e_rd : 32'h0;
        e_ird = (e_done && own == 2) ? e_rd : 32'h0;
        e_mem = e_iss ? {1'b1, pw[w], pm[w], pa[w], pd[w]} : '0;

        @(negedge clock);
        o_busy   = {bus.top_busy, bus.lsu_busy, bus.ifu_busy};
        o_resp   = {bus.top_respValid, bus.lsu_respValid, bus.ifu_respValid};
        o_mreq   = bus.mem_reqValid;
        o_mwen   = bus.mem_wen;
        o_mmask  = bus.mem_wbmask;
        o_maddr  = bus.mem_addr;
        o_mwdata = bus.mem_wdata;
        o_lrd    = bus.lsu_rdata;
        o_ird    = bus.ifu_rdata;
        o_err    = bus.arb_err;
        chk("busy", 128'(o_busy), 128'({pv[0], pv[1], pv[2]}));
        chk("resp", 128'(o_resp), 128'(e_resp));
        chk("mem_req", 128'({o_mreq, o_mwen, o_mmask, o_maddr, o_mwdata}),
            128'(e_mem));
        chk("rdata", 128'({o_lrd, o_ird}), 128'({e_lrd, e_ird}));
        chk("arb_err", 128'(o_err), 128'(err));

        req = '{bus.top_reqValid, bus.lsu_reqValid, bus.ifu_reqValid};
        if (reset) begin
            pv = '{0, 0, 0};
            fly = 0;
            streak = 0;
            err = 0;
        end else begin
            if (!pv[2] || (e_iss && w == 2)) streak = 0;
            else if (e_iss && w == 1)        streak++;
            if (req[0] && !pv[0]) begin
                pv[0] = 1; pa[0] = bus.top_addr; pd[0] = bus.top_wdata;
                pm[0] = 4'hF; pw[0] = 1;
            end
            if (req[1] && !pv[1]) begin
                pv[1] = 1; pa[1] = bus.lsu_addr; pd[1] = bus.lsu_wdata;
                pm[1] = bus.lsu_wbmask; pw[1] = bus.lsu_wen;
            end
            if (req[2] && !pv[2]) begin
                pv[2] = 1; pa[2] = bus.ifu_addr; pd[2] = 32'h0;
                pm[2] = 4'h0; pw[2] = 0;
            end
            if (e_done) begin
                pv[own] = 0;
                fly = 0;
                if (e_to) err = 1;
            end
            if (e_iss) begin
                fly = 1;
                own = w;
                iss = cyc;
                lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int          n, n_lsu, got;
        logic [31:0] rd, ea;
        idle_inputs();
        mem_auto = 0;
        pv = '{0, 0, 0};
        fly = 0; err = 0; own = 0; iss = 0; lat = 0; streak = 0; cyc = 0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        idle_inputs();

        // reset state
        tick();
        chk("rst_out", 128'({o_busy, o_resp, o_mreq, o_err, o_lrd, o_ird}), 128'(0));

        // LSU read, L=2
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h8000_0010;
        tick();
        tick();
        chk("rd_issue", 128'({o_mreq, o_mwen, o_maddr}), 128'({2'b10, 32'h8000_0010}));
        chk("rd_busy_a", 128'(o_busy), 128'(3'b010));
        tick();
        chk("rd_busy_b", 128'(o_busy), 128'(3'b010));
        bus.mem_respValid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_resp", 128'({o_resp, o_lrd, o_busy}), 128'({3'b010, 32'hDEAD_BEEF, 3'b010}));
        tick();
        chk("rd_busy_end", 128'(o_busy), 128'(0));

        // three-way collision
        do_reset();
        bus.top_reqValid = 1; bus.top_addr = 32'h100; bus.top_wdata = 32'h11;
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h200;
        bus.lsu_wen = 1; bus.lsu_wbmask = 4'b0011; bus.lsu_wdata = 32'h22;
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h300;
        tick();
        for (int k = 0; k < 3; k++) begin
            ea = 32'h100 * (k + 1);
            tick();
            chk("col_addr", 128'({o_mreq, o_maddr}), 128'({1'b1, ea}));
            if (k == 0) chk("col_mask", 128'(o_mmask), 128'(4'hF));
            bus.mem_respValid = 1; bus.mem_rdata = $urandom;
            tick();
            chk("col_resp", 128'(o_resp), 128'(3'b100 >> k));
        end

        // LSU streak vs pending IFU
        do_reset();
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h200;
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h300;
        tick();
        n_lsu = 0; got = 0;
        for (int k = 0; k < 8 && got == 0; k++) begin
            tick();
            if (o_mreq && o_maddr == 32'h300)      got = 1;
            else if (o_mreq && o_maddr == 32'h200) n_lsu++;
            bus.mem_respValid = 1; bus.mem_rdata = k;
            tick();
            bus.lsu_reqValid = 1; bus.lsu_addr = 32'h200; bus.mem_busy = 1;
            tick();
        end
        chk("starve_lsu", 128'(n_lsu), 128'(MAXS));
        chk("starve_ifu", 128'(got), 128'(1));

        // timeout
        do_reset();
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h600;
        tick();
        tick();
        chk("to_issue", 128'(o_mreq), 128'(1));
        n = 0; got = 0; rd = '0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            n++;
            if (o_resp[0]) begin
                got = 1;
                rd = o_ird;
            end
        end
        chk("to_lat", 128'(n), 128'(TMO));
        chk("to_rdata", 128'(rd), 128'(32'hFFFF_FFFF));
        tick();
        chk("to_err", 128'(o_err), 128'(1));
        repeat (5) tick();
        chk("to_err_hold", 128'(o_err), 128'(1));
        do_reset();
        chk("to_err_clr", 128'(o_err), 128'(0));

        // reset one cycle after issue, then a late response
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h700;
        tick();
        tick();
        reset = 1;
        tick();
        bus.mem_respValid = 1; bus.mem_rdata = 32'h1234_5678;
        tick();
        chk("mrst_quiet", 128'({o_resp, o_busy, o_lrd}), 128'(0));
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h704;
        tick();
        tick();
        chk("mrst_idle", 128'({o_mreq, o_maddr}), 128'({1'b1, 32'h704}));

        // request while busy, then memory stall
        do_reset();
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h40;
        bus.lsu_wen = 1; bus.lsu_wbmask = 4'b0101; bus.lsu_wdata = 32'hCAFE;
        tick();
        tick();
        bus.lsu_reqValid = 1; bus.lsu_addr = 32'h44;
        tick();
        chk("bp_busy", 128'(o_busy), 128'(3'b010));
        bus.mem_respValid = 1;
        tick();
        chk("bp_resp", 128'(o_resp), 128'(3'b010));
        n = 0;
        repeat (3) begin
            tick();
            if (o_mreq) n++;
        end
        chk("bp_noissue", 128'(n), 128'(0));
        bus.ifu_reqValid = 1; bus.ifu_addr = 32'h500;
        tick();
        n = 0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_busy = 1;
            tick();
            if (o_mreq) n++;
        end
        chk("stall_hold", 128'({n, o_busy}), 128'({32'd0, 3'b001}));
        tick();
        chk("stall_issue", 128'({o_mreq, o_maddr}), 128'({1'b1, 32'h500}));

        // randomized traffic with a reactive memory
        do_reset();
        mem_auto = 1;
        repeat (3000) begin
            bus.top_reqValid = ($urandom_range(0, 3) == 0);
            bus.lsu_reqValid = ($urandom_range(0, 2) == 0);
            bus.ifu_reqValid = ($urandom_range(0, 2) == 0);
            bus.top_addr     = $urandom;
            bus.lsu_addr     = $urandom;
            bus.ifu_addr     = $urandom;
            bus.top_wdata    = $urandom;
            bus.lsu_wdata    = $urandom;
            bus.lsu_wen      = 1'($urandom_range(0, 1));
            bus.lsu_wbmask   = 4'($urandom_range(0, 15));
            bus.mem_busy     = ($urandom_range(0, 4) == 0);
            reset            = ($urandom_range(0, 299) == 0);
            tick();
        end
        mem_auto = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
